// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage register: state encoding
// and the bubble (NOP) payload for each pipeline boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_FULL  = 2'd1,
    PIPE_SKID  = 2'd2
  } pipe_state_e;

  localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteDisable = 1'b0;

  // {pc, inst}
  localparam int          IFID_W   = 64;
  localparam logic [63:0] IFID_NOP = {ZeroWord, ZeroWord};

  // {aluop, alusel, reg1, reg2, wd, wreg}
  localparam int          IDEX_W   = 81;
  localparam logic [80:0] IDEX_NOP = {EXE_NOP_OP, EXE_RES_NOP, ZeroWord, ZeroWord,
                                      NOPRegAddr, WriteDisable};

  // {wd, wreg, wdata}
  localparam int          EXMEM_W   = 38;
  localparam logic [37:0] EXMEM_NOP = {NOPRegAddr, WriteDisable, ZeroWord};
  localparam int          MEMWB_W   = 38;
  localparam logic [37:0] MEMWB_NOP = {NOPRegAddr, WriteDisable, ZeroWord};

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional
// two-entry skid buffer, flush and NOP-bubble output.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter bit               SKID      = 1'b1,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  generate
    if (SKID) begin : g_skid
      pipe_state_e      state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             in_ready_q;
      logic             acc, dep;

      assign acc = in_valid && in_ready_q;
      assign dep = out_valid && out_ready;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = PIPE_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end else begin
          case (state_q)
            PIPE_EMPTY: begin
              if (acc) begin
                state_d = PIPE_FULL;
                main_d  = in_data;
              end
            end
            PIPE_FULL: begin
              if (acc && dep) begin
                main_d = in_data;
              end else if (acc) begin
                state_d = PIPE_SKID;
                skid_d  = in_data;
              end else if (dep) begin
                state_d = PIPE_EMPTY;
                main_d  = NOP_VALUE;
              end
            end
            PIPE_SKID: begin
              if (dep) begin
                state_d = PIPE_FULL;
                main_d  = skid_q;
                skid_d  = NOP_VALUE;
              end
            end
            default: begin
              state_d = PIPE_EMPTY;
              main_d  = NOP_VALUE;
              skid_d  = NOP_VALUE;
            end
          endcase
        end
      end

      // Ready is registered from the next state, so out_ready never reaches in_ready.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q    <= PIPE_EMPTY;
          main_q     <= NOP_VALUE;
          skid_q     <= NOP_VALUE;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= (state_d != PIPE_SKID);
        end
      end

      assign in_ready  = in_ready_q;
      assign out_valid = (state_q != PIPE_EMPTY);
      assign out_data  = main_q;
    end else begin : g_noskid
      pipe_state_e      state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic             acc, dep;

      assign out_valid = (state_q != PIPE_EMPTY);
      assign in_ready  = !out_valid || out_ready;
      assign acc       = in_valid && in_ready;
      assign dep       = out_valid && out_ready;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
          state_d = PIPE_EMPTY;
          main_d  = NOP_VALUE;
        end else if (acc) begin
          state_d = PIPE_FULL;
          main_d  = in_data;
        end else if (dep) begin
          state_d = PIPE_EMPTY;
          main_d  = NOP_VALUE;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= PIPE_EMPTY;
          main_q  <= NOP_VALUE;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
        end
      end

      assign out_data = main_q;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue model checked every cycle against a
// skid instance (CNT_W=3, NOP 0xDEAD0000) and a non-skid instance.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP_S = 32'hDEAD_0000;
  localparam logic [31:0] NOP_N = 32'h0000_0000;
  localparam int          MAX_S = 7;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s, flush_s, in_valid_s, in_ready_s, out_valid_s, out_ready_s;
  logic [31:0] in_data_s, out_data_s;
  logic [2:0]  stall_s;

  logic        rst_n, flush_n, in_valid_n, in_ready_n, out_valid_n, out_ready_n;
  logic [31:0] in_data_n, out_data_n;
  logic [15:0] stall_n;

  pipe_stage_reg #(.WIDTH(32), .NOP_VALUE(NOP_S), .SKID(1'b1), .CNT_W(3)) u_skid (
    .clk(clk), .rst(rst_s), .flush(flush_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s),
    .stall_cnt(stall_s)
  );

  pipe_stage_reg #(.WIDTH(32), .NOP_VALUE(NOP_N), .SKID(1'b0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst_n), .flush(flush_n),
    .in_valid(in_valid_n), .in_ready(in_ready_n), .in_data(in_data_n),
    .out_valid(out_valid_n), .out_ready(out_ready_n), .out_data(out_data_n),
    .stall_cnt(stall_n)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of capacity 2 (skid) or 1 (no skid); flush empties it.
  logic [31:0] qs[$];
  logic [31:0] qn[$];
  int          cnt_s = 0;
  int          cnt_n = 0;

  always @(posedge clk) begin : model_s
    bit acc, dep;
    if (rst_s) begin
      qs.delete();
      cnt_s <= 0;
    end else begin
      acc = in_valid_s && (qs.size() < 2);
      dep = (qs.size() > 0) && out_ready_s;
      if ((qs.size() > 0) && !out_ready_s && (cnt_s < MAX_S)) cnt_s <= cnt_s + 1;
      if (flush_s) begin
        qs.delete();
      end else begin
        if (dep) begin
          $display("[%0t] skid   out %h", $time, qs[0]);
          void'(qs.pop_front());
        end
        if (acc) qs.push_back(in_data_s);
      end
    end
  end

  always @(posedge clk) begin : model_n
    bit acc, dep;
    if (rst_n) begin
      qn.delete();
      cnt_n <= 0;
    end else begin
      acc = in_valid_n && ((qn.size() == 0) || out_ready_n);
      dep = (qn.size() > 0) && out_ready_n;
      if ((qn.size() > 0) && !out_ready_n) cnt_n <= cnt_n + 1;
      if (flush_n) begin
        qn.delete();
      end else begin
        if (dep) begin
          $display("[%0t] noskid out %h", $time, qn[0]);
          void'(qn.pop_front());
        end
        if (acc) qn.push_back(in_data_n);
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      chk("s_out_valid", {31'b0, out_valid_s}, {31'b0, qs.size() > 0});
      chk("s_out_data", out_data_s, (qs.size() > 0) ? qs[0] : NOP_S);
      chk("s_in_ready", {31'b0, in_ready_s}, {31'b0, qs.size() < 2});
      chk("s_stall", {29'b0, stall_s}, cnt_s);
      chk("n_out_valid", {31'b0, out_valid_n}, {31'b0, qn.size() > 0});
      chk("n_out_data", out_data_n, (qn.size() > 0) ? qn[0] : NOP_N);
      chk("n_in_ready", {31'b0, in_ready_n}, {31'b0, (qn.size() == 0) || out_ready_n});
      chk("n_stall", {16'b0, stall_n}, cnt_n);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_s(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid_s = v; in_data_s = d; out_ready_s = ordy; flush_s = fl;
  endtask

  initial begin
    rst_s = 1'b1; flush_s = 1'b0; in_valid_s = 1'b0; in_data_s = '0; out_ready_s = 1'b0;
    rst_n = 1'b1; flush_n = 1'b0; in_valid_n = 1'b0; in_data_n = '0; out_ready_n = 1'b0;
    repeat (2) cyc();
    chk("s_reset_valid", {31'b0, out_valid_s}, 32'd0);
    chk("s_reset_data", out_data_s, 32'hDEAD_0000);
    chk("s_reset_ready", {31'b0, in_ready_s}, 32'd1);
    chk("n_reset_ready", {31'b0, in_ready_n}, 32'd1);
    rst_s = 1'b0; rst_n = 1'b0;
    chk_en = 1'b1;

    // Streaming
    drv_s(1, 32'h1, 1, 0); cyc(); chk("stream1", out_data_s, 32'h1);
    drv_s(1, 32'h2, 1, 0); cyc(); chk("stream2", out_data_s, 32'h2);
    drv_s(1, 32'h3, 1, 0); cyc(); chk("stream3", out_data_s, 32'h3);
    drv_s(0, 32'h0, 1, 0); cyc();
    chk("stream_end_valid", {31'b0, out_valid_s}, 32'd0);
    chk("stream_stall", {29'b0, stall_s}, 32'd0);

    // Bubble encoding while idle
    repeat (3) cyc();
    chk("bubble_data", out_data_s, 32'hDEAD_0000);

    // Skid fill and drain
    drv_s(1, 32'hA, 1, 0); cyc(); chk("skid_a", out_data_s, 32'hA);
    drv_s(1, 32'hB, 0, 0); cyc();
    chk("skid_ready_drop", {31'b0, in_ready_s}, 32'd0);
    chk("skid_stall1", {29'b0, stall_s}, 32'd1);
    drv_s(1, 32'hC, 0, 0); cyc();
    chk("skid_hold_a", out_data_s, 32'hA);
    chk("skid_stall2", {29'b0, stall_s}, 32'd2);
    drv_s(1, 32'hC, 1, 0); cyc();
    chk("drain_b", out_data_s, 32'hB);
    chk("drain_ready", {31'b0, in_ready_s}, 32'd1);
    cyc(); chk("drain_c", out_data_s, 32'hC);
    drv_s(0, 32'h0, 1, 0); cyc();
    chk("drain_empty", {31'b0, out_valid_s}, 32'd0);

    // Flush while both entries held
    drv_s(1, 32'hA, 0, 0); cyc();
    drv_s(1, 32'hB, 0, 0); cyc();
    drv_s(1, 32'hD, 0, 1); cyc();
    chk("flush_valid", {31'b0, out_valid_s}, 32'd0);
    chk("flush_data", out_data_s, 32'hDEAD_0000);
    chk("flush_ready", {31'b0, in_ready_s}, 32'd1);
    drv_s(0, 32'h0, 1, 0); repeat (3) cyc();
    chk("flush_stall", {29'b0, stall_s}, 32'd4);

    // Counter saturation, survives flush, cleared by reset
    drv_s(1, 32'h5, 0, 0); cyc();
    drv_s(0, 32'h0, 0, 0); repeat (10) cyc();
    chk("sat_7", {29'b0, stall_s}, 32'd7);
    drv_s(0, 32'h0, 0, 1); cyc();
    drv_s(0, 32'h0, 0, 0);
    chk("sat_after_flush", {29'b0, stall_s}, 32'd7);
    rst_s = 1'b1; cyc(); rst_s = 1'b0;
    chk("sat_after_rst", {29'b0, stall_s}, 32'd0);

    // No-skid variant: combinational ready, mid-operation reset
    in_valid_n = 1'b1; in_data_n = 32'h11; out_ready_n = 1'b0; cyc();
    chk("n_ready_low", {31'b0, in_ready_n}, 32'd0);
    out_ready_n = 1'b1; #1;
    chk("n_ready_comb", {31'b0, in_ready_n}, 32'd1);
    in_data_n = 32'h22; cyc();
    chk("n_stream", out_data_n, 32'h22);
    in_data_n = 32'h33; out_ready_n = 1'b0; cyc();
    chk("n_held", out_data_n, 32'h22);
    chk("n_stall1", {16'b0, stall_n}, 32'd1);
    rst_n = 1'b1; cyc();
    chk("n_rst_valid", {31'b0, out_valid_n}, 32'd0);
    chk("n_rst_data", out_data_n, 32'h0);
    chk("n_rst_stall", {16'b0, stall_n}, 32'd0);
    rst_n = 1'b0; in_valid_n = 1'b0; out_ready_n = 1'b1;
    repeat (3) cyc();

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and NOP-bubble insertion. It replaces the fixed-payload, stall-vector-driven inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Each stage boundary instantiates it with its own payload width and NOP encoding. Per-stage back-pressure replaces the global stall vector, and a saturating stall-cycle counter is exported for performance monitoring.

## Interface
- `WIDTH`, 32: payload width in bits; any integer ≥ 1.
- `NOP_VALUE`, {WIDTH{1'b0}}: payload driven on `out_data` whenever `out_valid`=0. This is the bubble encoding: NOP aluop/alusel, zero operands, write disabled.
- `SKID`, 1: 1 = two-entry registered-ready buffer; 0 = single entry with combinational ready.
- `CNT_W`, 16: width of the stall-cycle counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all held entries (branch mispredict / redirect).
- `in_valid`  in  1  upstream has a payload.
- `in_ready`  out  1  block can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  payload presented downstream.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  presented payload, or `NOP_VALUE` when invalid.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready` at a rising edge.
- State (SKID=1):
  - EMPTY: main and skid entries invalid.
  - FULL: main valid, skid invalid.
  - SKID: both valid.
- Transitions, with `acc` = transfer in and `dep` = transfer out:
  - EMPTY: `acc` → FULL, main ← `in_data`.
  - FULL: `acc&&dep` → FULL, main ← `in_data`. `acc&&!dep` → SKID, skid ← `in_data`. `!acc&&dep` → EMPTY. Otherwise hold.
  - SKID: `dep` → FULL, main ← skid. Otherwise hold. `in_ready`=0, so no accept occurs in SKID.
- SKID=1: `in_ready` = registered (state != SKID). There is no combinational path from `out_ready` to `in_ready`.
- SKID=0: only EMPTY/FULL exist. `in_ready` = !`out_valid` || `out_ready`, combinationally.
- `out_valid` = (state != EMPTY). `out_data` = main if valid, else `NOP_VALUE`. It is driven from a register, not muxed after the flop.
- Ordering is strict FIFO: a skid entry always departs after the main entry it queued behind.
- `flush` priority is below `rst` and above everything else:
  - Next state is EMPTY and `out_data` becomes `NOP_VALUE`.
  - A payload offered during the flush cycle is dropped, even if `in_ready`=1. Upstream treats the handshake as consumed.
  - `out_ready` during the flush cycle is ignored.
- `stall_cnt`:
  - Increments by 1 every cycle with `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by `rst`; not cleared by `flush`.
- Reset values: state EMPTY, `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1 (SKID=1; for SKID=0 it follows from `out_valid`=0), `stall_cnt`=0. Skid contents are don't-care but are reset to `NOP_VALUE` for determinism.
- Reset asserted mid-transfer wins over all handshakes that cycle. Held payloads are lost.

## Timing
- Latency: data accepted at edge N appears on `out_data` with `out_valid`=1 immediately after edge N (visible in cycle N+1).
- Throughput: 1 transfer per cycle with `out_ready` held high, in both modes.
- SKID=1: after `out_ready` falls, exactly one more payload is accepted (into skid). `in_ready` drops the following cycle.
- SKID=1: `in_ready` returns to 1 one cycle after the first departure from SKID.
- `flush`: `out_valid`=0 and `in_ready`=1 in the cycle after the flush edge. A new payload may be accepted in that cycle.

## Structure
- Shared package `pipe_pkg`: state encoding `PIPE_EMPTY`/`PIPE_FULL`/`PIPE_SKID` (2 bits), plus per-stage NOP payload constants (e.g. `IDEX_NOP`) built from the existing `EXE_NOP_OP`, `EXE_RES_NOP`, `ZeroWord`, `NOPRegAddr` and `WriteDisable` defines.
- One sub-module is natural: `sat_counter` (parameter `W`; ports `clk`, `rst`, `inc`, `count`), used for `stall_cnt`.
- The SKID=0/1 variants are generate branches in the same module.

## Test plan
- Streaming: WIDTH=32, `out_ready`=1, inputs 0x1,0x2,0x3 on consecutive cycles → same values on `out_data` one cycle later, back-to-back; `stall_cnt`=0.
- Skid fill/drain: accept 0xA; drop `out_ready`; offer 0xB, 0xC → 0xB accepted, `in_ready`=0 next cycle, 0xC held upstream. `stall_cnt` counts each blocked cycle. Raise `out_ready` → A, B, C emerge in order.
- Flush in SKID state: hold 0xA/0xB, assert `flush` with `in_valid`=1 and `in_data`=0xD → next cycle `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1; 0xD never appears.
- Bubble encoding: `NOP_VALUE`=0xDEAD_0000, idle input → `out_data`=0xDEAD_0000 continuously, `out_valid`=0.
- Counter saturation: CNT_W=3, `out_valid`=1, `out_ready`=0 for 10 cycles → `stall_cnt` stops at 7. `flush` leaves 7; `rst` → 0.
- SKID=0 and mid-operation reset: `out_ready`=0 with `out_valid`=1 → `in_ready`=0 in the same cycle. Assert `rst` while full → next cycle all outputs at their reset values.
